// File: rtl/inst_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : inst_mem_ctrl_if
// Brief   : Program-load and fetch request/response bundle for inst_mem_ctrl.
// Rev     : 1.0
// ============================================================================
interface inst_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_inst;
  logic [31:0]       rsp_pc;
  logic [1:0]        rsp_fault;

  modport master (
    output ld_en, ld_addr, ld_data, req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault
  );
endinterface
`default_nettype wire

// File: rtl/inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : inst_mem_ctrl
// Brief   : Loadable instruction RAM with a 1-cycle registered fetch port.
// Rev     : 1.0
// ============================================================================
module inst_mem_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input  wire              clk,
  input  wire              rst,
  inst_mem_ctrl_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] c_FAULT_OK    = 2'b00;
  localparam logic [1:0] c_FAULT_ALIGN = 2'b01;
  localparam logic [1:0] c_FAULT_RANGE = 2'b10;
  localparam logic [1:0] c_FAULT_UNWR  = 2'b11;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_written;

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_inst;
  logic [31:0]       r_rsp_pc;
  logic [1:0]        r_rsp_fault;

  logic              w_req_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_index;
  logic              w_hi_nz;
  logic [1:0]        w_fault;
  logic [DATA_W-1:0] w_inst;

  // Loads win over fetches so a program image streams in without interleaving.
  assign w_req_ready = !rst && !bus.ld_en && (!r_rsp_valid || bus.rsp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_index     = bus.req_addr[ADDR_W+1:2];
  assign w_hi_nz     = |bus.req_addr[31:ADDR_W+2];

  always_comb begin
    w_fault = c_FAULT_OK;
    w_inst  = NOP_WORD;
    if (bus.req_addr[1:0] != 2'b00) begin
      w_fault = c_FAULT_ALIGN;
    end else if (w_hi_nz) begin
      w_fault = c_FAULT_RANGE;
    end else if (!r_written[w_index]) begin
      w_fault = c_FAULT_UNWR;
    end else begin
      w_inst = r_mem[w_index];
    end
  end

  // Array contents deliberately survive reset; only the written flags clear.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      r_mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_written <= '0;
    end else if (bus.ld_en) begin
      r_written[bus.ld_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_inst  <= '0;
      r_rsp_pc    <= '0;
      r_rsp_fault <= c_FAULT_OK;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_inst  <= w_inst;
      r_rsp_pc    <= bus.req_addr;
      r_rsp_fault <= w_fault;
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_inst  = r_rsp_inst;
  assign bus.rsp_pc    = r_rsp_pc;
  assign bus.rsp_fault = r_rsp_fault;
endmodule
`default_nettype wire

// File: tb/tb_inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_mem_ctrl
// Brief   : Scoreboard bench for inst_mem_ctrl with a behavioural memory model.
// Rev     : 1.0
// ============================================================================
module tb_inst_mem_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } rsp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  rsp_t sb[$];

  logic [31:0] m_mem [DEPTH];
  bit          m_written [DEPTH];
  logic        m_valid;

  inst_mem_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  inst_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t model_fetch(input logic [31:0] addr);
    rsp_t r;
    r.pc   = addr;
    r.inst = 32'h0;
    if (addr % 4 != 0)                r.fault = 2'd1;
    else if (addr >= DEPTH * 4)       r.fault = 2'd2;
    else if (!m_written[addr / 4])    r.fault = 2'd3;
    else begin
      r.fault = 2'd0;
      r.inst  = m_mem[addr / 4];
    end
    return r;
  endfunction

  // Reference model: predicts handshake and response, pushes expectation on the accept edge.
  always @(negedge clk) begin
    logic exp_ready;
    logic acc;
    rsp_t e;
    if (rst) begin
      m_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
    end else begin
      exp_ready = !bus.ld_en && (!m_valid || bus.rsp_ready);
      check("req_ready", {63'd0, bus.req_ready}, {63'd0, exp_ready});
      check("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, m_valid});
      acc = bus.req_valid && exp_ready;
      if (acc) e = model_fetch(bus.req_addr);
      if (bus.ld_en) begin
        m_mem[int'(bus.ld_addr)]     = bus.ld_data;
        m_written[int'(bus.ld_addr)] = 1'b1;
      end
      if (acc) m_valid = 1'b1;
      else if (m_valid && bus.rsp_ready) m_valid = 1'b0;
      if (acc) begin
        @(posedge clk);
        sb.push_back(e);
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = sb[0];
        check("rsp_inst",  {32'd0, bus.rsp_inst}, {32'd0, e.inst});
        check("rsp_pc",    {32'd0, bus.rsp_pc},   {32'd0, e.pc});
        check("rsp_fault", {62'd0, bus.rsp_fault}, {62'd0, e.fault});
        if (bus.rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input logic ld, input int la, input logic [31:0] ldd,
                       input logic rv, input logic [31:0] ra, input logic rr);
    @(posedge clk);
    #1;
    bus.ld_en     = ld;
    bus.ld_addr   = la[4:0];
    bus.ld_data   = ldd;
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.rsp_ready = rr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_rsp_inst",  {32'd0, bus.rsp_inst}, 64'd0);
    check("rst_rsp_pc",    {32'd0, bus.rsp_pc}, 64'd0);
    check("rst_rsp_fault", {62'd0, bus.rsp_fault}, 64'd0);
    bus.req_valid = 1'b1;
    #1;
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;

    // Unwritten word straight after reset, then load and refetch.
    drive(1'b0, 0, 32'h0, 1'b1, 32'h14, 1'b1);
    drive(1'b1, 5, 32'h00221820, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 0, 32'h0, 1'b1, 32'h14, 1'b1);
    idle(1);

    // Program load then back-to-back fetches.
    drive(1'b1, 0, 32'h20010008, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1, 32'h3402000C, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 0, 32'h0, 1'b1, 32'h0, 1'b1);
    drive(1'b0, 0, 32'h0, 1'b1, 32'h4, 1'b1);
    drive(1'b0, 0, 32'h0, 1'b1, 32'h6, 1'b1);
    drive(1'b0, 0, 32'h0, 1'b1, 32'h80, 1'b1);
    idle(2);

    // Backpressure: hold for three cycles with a second request waiting.
    drive(1'b0, 0, 32'h0, 1'b1, 32'h0, 1'b1);
    repeat (3) drive(1'b0, 0, 32'h0, 1'b1, 32'h4, 1'b0);
    drive(1'b0, 0, 32'h0, 1'b1, 32'h4, 1'b1);
    idle(2);

    // Load stalls fetch for both load cycles.
    drive(1'b1, 2, 32'hCAFE0002, 1'b1, 32'h8, 1'b1);
    drive(1'b1, 3, 32'hCAFE0003, 1'b1, 32'h8, 1'b1);
    drive(1'b0, 0, 32'h0, 1'b1, 32'h8, 1'b1);
    idle(2);

    // Load into the held word must not disturb the held response.
    drive(1'b0, 0, 32'h0, 1'b1, 32'h0, 1'b0);
    drive(1'b1, 0, 32'h11111111, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b1);
    idle(1);

    // Reset while a response is held.
    drive(1'b0, 0, 32'h0, 1'b1, 32'h4, 1'b0);
    drive(1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midhold_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    sb.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 0, 32'h0, 1'b1, 32'h4, 1'b1);
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic        ld;
      logic        rv;
      logic        rr;
      logic [31:0] ra;
      ld = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1:       ra = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        2:       ra = 32'(DEPTH * 4 + $urandom_range(0, 255) * 4);
        default: ra = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      drive(ld, $urandom_range(0, DEPTH - 1), $urandom, rv, ra, rr);
    end

    // Drain outstanding responses within a bounded number of cycles.
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(1);
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/inst_mem_ctrl.md
Name: inst_mem_ctrl

Overview:
Parametrised, loadable instruction memory with a registered fetch port. It replaces fixed combinational ROM tables with a RAM array that is written through a program-load port and read through a valid/ready request/response handshake. Each response reports a fault code for misaligned, out-of-range or never-written addresses. It sits between the PC/fetch stage and the decode stage of the CPU.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 32, number of instruction words; power of two, >= 2
ADDR_W, $clog2(DEPTH), word-index width; derived localparam, not overridable
NOP_WORD, 32'h00000000, value returned on any faulted fetch

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
ld_en  input  1  program-load write strobe
ld_addr  input  ADDR_W  word index to write
ld_data  input  DATA_W  instruction word to write
req_valid  input  1  fetch request valid
req_ready  output  1  fetch request can be accepted this cycle
req_addr  input  32  byte address of fetch (PC)
rsp_valid  output  1  fetch response valid
rsp_ready  input  1  consumer accepts response
rsp_inst  output  DATA_W  fetched instruction, or NOP_WORD on fault
rsp_pc  output  32  req_addr of the request that produced this response
rsp_fault  output  2  00 ok, 01 misaligned, 10 out of range, 11 unwritten

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_inst=0, rsp_pc=0, rsp_fault=00, and every per-word written flag is cleared. Array contents are not cleared. req_ready is combinational and evaluates to 0 while rst=1.
- Storage: DEPTH x DATA_W array plus a DEPTH-bit written-flag vector.
- Load: when ld_en=1 on a rising edge, array[ld_addr] <= ld_data and written[ld_addr] <= 1. ld_addr is always in range by width. Loads never touch the response registers.
- req_ready = !rst & !ld_en & (!rsp_valid | rsp_ready). Load has priority: fetches stall for every cycle ld_en is high.
- Accept: a request is accepted on a rising edge with req_valid & req_ready. Word index = req_addr[ADDR_W+1:2].
- Response timing: the response registers load on the same edge that accepts the request, so rsp_valid=1 in the following cycle (1-cycle latency). Back-to-back accepts give one response per cycle when rsp_ready stays high.
- Fault priority (first match wins):
  - req_addr[1:0] != 0 gives 01.
  - Any of req_addr[31:ADDR_W+2] nonzero gives 10.
  - written[index]=0 gives 11.
  - Otherwise 00.
- On any fault, rsp_inst = NOP_WORD; otherwise rsp_inst = array[index] as read at the accept edge. rsp_pc = req_addr in all cases.
- Hold: while rsp_valid & !rsp_ready, rsp_inst, rsp_pc and rsp_fault stay stable and no new request is accepted.
- Retire: rsp_valid & rsp_ready with no new accept on that edge clears rsp_valid to 0 on that edge. Output data regs keep their last values.
- A load to the word of a response that is already held does not alter that held response.
- Reset asserted mid-hold drops rsp_valid immediately; the held response is lost.

Test Plan:
- Load word 0 = 0x20010008 and word 1 = 0x3402000C, then fetch addrs 0x0 and 0x4 back-to-back with rsp_ready=1 -> responses 0x20010008/00 then 0x3402000C/00 on consecutive cycles, rsp_pc 0x0 then 0x4.
- Fetch 0x00000006 -> rsp_fault=01, rsp_inst=0x00000000, rsp_pc=0x6. With DEPTH=32, fetch 0x00000080 -> rsp_fault=10, rsp_inst=0x00000000.
- After reset, fetch 0x14 (word 5, never loaded) -> rsp_fault=11, rsp_inst=0x00000000. Then load word 5 = 0x00221820 and refetch -> 0x00221820/00.
- Backpressure: first response pending and rsp_ready=0 for 3 cycles while req_valid stays 1 -> req_ready=0, outputs constant for 3 cycles. Second request is accepted on the edge where rsp_ready=1, and its response appears the next cycle.
- ld_en held high for 2 cycles while req_valid=1 -> req_ready=0 for both cycles, no response produced. Fetch proceeds on the first cycle after ld_en falls.
- Assert rst while a response is held -> rsp_valid drops before the next clock edge. Refetch of a previously loaded word -> rsp_fault=11.
